// File: rtl/encoder_frame_stacker_if.sv
// Valid/ready bundle for the encoder frame stacker.
// Carries both the upstream (in_*) and downstream (out_*) handshakes.
interface encoder_frame_stacker_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int KW = $clog2(DATA_WIDTH + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [KW-1:0]         in_k;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [KW-1:0]         out_k;
    logic                  out_last;

    modport master (
        output in_valid, in_data, in_k, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_k, out_last
    );

    modport slave (
        input  in_valid, in_data, in_k, in_last, out_ready,
        output in_ready, out_valid, out_data, out_k, out_last
    );
endinterface

// File: rtl/encoder_frame_stacker.sv
// LIFO frame reorderer: collects a frame of code words, replays it reversed.
// Optional k legality check enabled by defining ENC_STACK_KCHECK_EN.
module encoder_frame_stacker #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int STACK_DEPTH = 16,
    localparam int KW          = $clog2(DATA_WIDTH + 1),
    localparam int CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    encoder_frame_stacker_if.slave bus,
    output logic [CW-1:0]         frame_len,
    output logic                  overflow,
    output logic                  k_err
);
    localparam int AW = $clog2(STACK_DEPTH);
`ifdef ENC_STACK_KCHECK_EN
    localparam bit KCHECK = 1'b1;
`else
    localparam bit KCHECK = 1'b0;
`endif

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                   state, state_n;
    logic [CW-1:0]            ptr, ptr_n;
    logic [CW-1:0]            len_q, len_n;
    logic                     ovf_q, ovf_n;
    logic                     kerr_q, kerr_n;
    logic                     we;
    logic                     k_ok;
    logic [AW-1:0]            wr_idx;
    logic [AW-1:0]            rd_idx;
    logic [KW+DATA_WIDTH-1:0] rd_word;
    logic [KW+DATA_WIDTH-1:0] mem [STACK_DEPTH];

    assign wr_idx  = AW'(ptr);
    assign rd_idx  = AW'(ptr - CW'(1));
    assign rd_word = mem[rd_idx];

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        len_n   = len_q;
        ovf_n   = 1'b0;
        kerr_n  = 1'b0;
        we      = 1'b0;
        k_ok    = 1'b1;
        unique case (state)
            FILL: begin
                if (bus.in_valid) begin
                    if (KCHECK)
                        k_ok = (bus.in_k != '0) &&
                               (bus.in_k <= KW'(DATA_WIDTH));
                    // Full stack wins over a bad k: only overflow reports.
                    if (ptr == CW'(STACK_DEPTH)) begin
                        ovf_n = 1'b1;
                    end else if (!k_ok) begin
                        kerr_n = 1'b1;
                    end else begin
                        we    = 1'b1;
                        ptr_n = ptr + CW'(1);
                    end
                    if (bus.in_last && ptr_n != '0) begin
                        state_n = DRAIN;
                        len_n   = ptr_n;
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (ptr == CW'(1)) begin
                        state_n = FILL;
                        ptr_n   = '0;
                        len_n   = '0;
                    end else begin
                        ptr_n = ptr - CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            ptr    <= '0;
            len_q  <= '0;
            ovf_q  <= 1'b0;
            kerr_q <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            len_q  <= len_n;
            ovf_q  <= ovf_n;
            kerr_q <= kerr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst)
            mem[wr_idx] <= {bus.in_k, bus.in_data};
    end

    // Outputs are forced quiet while reset is held.
    logic drain;
    assign drain = (state == DRAIN) && !rst;

    assign bus.in_ready  = (state == FILL) && !rst;
    assign bus.out_valid = drain;
    assign bus.out_data  = drain ? rd_word[DATA_WIDTH-1:0] : '0;
    assign bus.out_k     = drain ? rd_word[KW+DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign bus.out_last  = drain && (ptr == CW'(1));
    assign frame_len     = rst ? '0 : len_q;
    assign overflow      = ovf_q && !rst;
    assign k_err         = kerr_q && !rst;
endmodule

// File: tb/tb_encoder_frame_stacker.sv
// Directed testbench for encoder_frame_stacker.
// Covers reset, order reversal, overflow, stalls, mid-drain reset, k handling.
module tb_encoder_frame_stacker;
    localparam int DW = 32;
    localparam int SD = 16;
    localparam int KW = $clog2(DW + 1);
    localparam int CW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] frame_len;
    logic          overflow;
    logic          k_err;

    int checks = 0;
    int errors = 0;

    encoder_frame_stacker_if #(.DATA_WIDTH(DW)) bus ();

    encoder_frame_stacker #(
        .DATA_WIDTH (DW),
        .STACK_DEPTH(SD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .frame_len(frame_len),
        .overflow (overflow),
        .k_err    (k_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_k     = k;
        bus.in_last  = last;
        chk("push_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [DW-1:0] d,
                       input logic [KW-1:0] k, input logic last);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"}, 64'(bus.out_data), 64'(d));
        chk({tag, "_k"}, 64'(bus.out_k), 64'(k));
        chk({tag, "_last"}, 64'(bus.out_last), 64'(last));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
        chk({tag, "_frame_len"}, 64'(frame_len), 64'd0);
    endtask

    initial begin
        logic [5:0] pat;
        logic [DW-1:0] exp_d [3];
        logic [KW-1:0] exp_k [3];
        int idx;
        int hs;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_k      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // reset values while rst is high
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_k", 64'(bus.out_k), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_frame_len", 64'(frame_len), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_k_err", 64'(k_err), 64'd0);
        rst = 1'b0;
        #1;
        idle_check("post_rst");

        // three-word frame reversed
        push(32'h1, 6'd1, 1'b0);
        push(32'h2, 6'd2, 1'b0);
        chk("t1_fill_valid", 64'(bus.out_valid), 64'd0);
        push(32'h3, 6'd3, 1'b1);
        chk("t1_in_ready_drain", 64'(bus.in_ready), 64'd0);
        chk("t1_frame_len", 64'(frame_len), 64'd3);
        pop("t1_w3", 32'h3, 6'd3, 1'b0);
        pop("t1_w2", 32'h2, 6'd2, 1'b0);
        pop("t1_w1", 32'h1, 6'd1, 1'b1);
        idle_check("t1_end");

        // 17 words into a 16-deep stack
        for (int i = 1; i <= 17; i++) begin
            push(DW'(i), 6'd5, i == 17);
            chk($sformatf("t2_ovf_%0d", i), 64'(overflow), 64'(i == 17));
        end
        chk("t2_frame_len", 64'(frame_len), 64'd16);
        for (int i = 16; i >= 1; i--) begin
            pop($sformatf("t2_w%0d", i), DW'(i), 6'd5, i == 1);
            if (i == 16)
                chk("t2_ovf_clear", 64'(overflow), 64'd0);
        end
        idle_check("t2_end");

        // drain with stalls
        push(32'd10, 6'd4, 1'b0);
        push(32'd20, 6'd5, 1'b0);
        push(32'd30, 6'd6, 1'b1);
        chk("t3_frame_len", 64'(frame_len), 64'd3);
        exp_d[0] = 32'd30; exp_k[0] = 6'd6;
        exp_d[1] = 32'd20; exp_k[1] = 6'd5;
        exp_d[2] = 32'd10; exp_k[2] = 6'd4;
        pat = 6'b101001;
        idx = 0;
        hs  = 0;
        for (int c = 0; c < 6; c++) begin
            bus.out_ready = pat[c];
            chk($sformatf("t3_c%0d_data", c), 64'(bus.out_data),
                64'(exp_d[idx]));
            chk($sformatf("t3_c%0d_k", c), 64'(bus.out_k), 64'(exp_k[idx]));
            chk($sformatf("t3_c%0d_last", c), 64'(bus.out_last),
                64'(idx == 2));
            tick();
            if (pat[c]) begin
                idx++;
                hs++;
            end
        end
        bus.out_ready = 1'b0;
        chk("t3_handshakes", 64'(hs), 64'd3);
        idle_check("t3_end");

        // reset in the middle of a drain
        for (int i = 1; i <= 4; i++)
            push(DW'(i), 6'd1, i == 4);
        pop("t4_w4", 32'd4, 6'd1, 1'b0);
        pop("t4_w3", 32'd3, 6'd1, 1'b0);
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t4_rst_data", 64'(bus.out_data), 64'd0);
        chk("t4_rst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("t4_rst_last", 64'(bus.out_last), 64'd0);
        rst = 1'b0;
        #1;
        idle_check("t4_post_rst");
        chk("t4_out_data", 64'(bus.out_data), 64'd0);
        chk("t4_out_k", 64'(bus.out_k), 64'd0);
        push(32'hAB, 6'd8, 1'b1);
        chk("t4_frame_len", 64'(frame_len), 64'd1);
        pop("t4_ab", 32'hAB, 6'd8, 1'b1);
        idle_check("t4_end");

`ifdef ENC_STACK_KCHECK_EN
        push(32'd5, 6'd0, 1'b0);
        chk("t5_kerr_a", 64'(k_err), 64'd1);
        push(32'd6, 6'd33, 1'b0);
        chk("t5_kerr_b", 64'(k_err), 64'd1);
        push(32'd7, 6'd4, 1'b1);
        chk("t5_kerr_c", 64'(k_err), 64'd0);
        chk("t5_frame_len", 64'(frame_len), 64'd1);
        pop("t5_w7", 32'd7, 6'd4, 1'b1);
`else
        push(32'd5, 6'd0, 1'b1);
        chk("t5_kerr", 64'(k_err), 64'd0);
        chk("t5_frame_len", 64'(frame_len), 64'd1);
        pop("t5_w5", 32'd5, 6'd0, 1'b1);
        chk("t5_kerr_end", 64'(k_err), 64'd0);
`endif
        idle_check("t5_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/encoder_frame_stacker.md
# encoder_frame_stacker

Encoder-side frame reorderer that feeds the DNA decoding path. It collects one frame of up to STACK_DEPTH code words, each a `data`/`k` pair where `k` is the number of valid bits, and replays them in last-in-first-out order. Because the `decoder_stack` unwinds them a second time, the decoder recovers the original word order. It sits between the codeword generator and the channel/output formatter, using valid/ready handshakes on both sides.

## Interface
Parameters:
- DATA_WIDTH, 32, code-word width in bits
- STACK_DEPTH, 16, maximum words per frame
- Derived, not overridable: KW = $clog2(DATA_WIDTH+1); CW = $clog2(STACK_DEPTH+1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  block accepts a word
- in_data  in  DATA_WIDTH  code word
- in_k  in  KW  valid-bit count of in_data
- in_last  in  1  word closes the frame
- out_valid  out  1  replay word valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  replayed word
- out_k  out  KW  replayed valid-bit count
- out_last  out  1  final replay word of the frame (first word received)
- frame_len  out  CW  words held in the frame being drained; 0 in FILL
- overflow  out  1  one-cycle pulse: a word was dropped because the stack was full
- k_err  out  1  one-cycle pulse: a word was dropped for an illegal k (only with ENC_STACK_KCHECK_EN)

## Operation
- Storage: STACK_DEPTH x (DATA_WIDTH+KW) memory; pointer `ptr` (0..STACK_DEPTH) = entries held.
- States: FILL and DRAIN. Reset enters FILL with ptr=0.
- FILL:
  - in_ready=1.
  - A handshake with ptr<STACK_DEPTH writes mem[ptr] and increments ptr.
  - A handshake with ptr==STACK_DEPTH drops the word and pulses overflow.
  - Any accepted handshake with in_last=1 moves the block to DRAIN, provided ptr after the update is nonzero. frame_len latches the new ptr.
- DRAIN:
  - in_ready=0; out_valid=1.
  - out_data and out_k come from mem[ptr-1]; out_last=(ptr==1).
  - A handshake (out_valid & out_ready) decrements ptr.
  - A handshake with out_last returns the block to FILL, with ptr=0 and frame_len=0.
- Stable outputs: out_data, out_k and out_last hold while out_valid=1 and out_ready=0.
- The k field is stored and returned unmodified. Data bits above k are passed through, not masked.
- No input and output overlap: input is never accepted in DRAIN, so push and pop cannot coincide.

## Timing
- Reset values (in the cycle rst is high and the cycle after): in_ready=0 while rst=1, then 1; out_valid=0, out_data=0, out_k=0, out_last=0, frame_len=0, overflow=0, k_err=0.
- Reset mid-frame or mid-drain: the block discards all contents, returns to FILL with ptr=0, and issues no out_last.
- FILL-to-DRAIN latency: a last word accepted at edge N gives out_valid=1 from edge N onward. The first replay word is the last word received.
- Drain throughput: one word per cycle while out_ready=1. A frame of n words drains in n cycles minimum.
- DRAIN-to-FILL: the out_last handshake at edge M gives in_ready=1 from edge M onward.
- Pulse timing: overflow and k_err are registered, high exactly one cycle after the offending handshake edge.
- Full plus last: a full stack receiving a last word drops the word, pulses overflow, and still enters DRAIN with frame_len=STACK_DEPTH.

## Configuration
- ENC_STACK_KCHECK_EN defined:
  - An accepted word with in_k==0 or in_k>DATA_WIDTH is not stored, and k_err pulses.
  - If that word carries in_last, the frame closes only when ptr>0. Otherwise in_last is ignored and the block stays in FILL.
  - The overflow check has priority over the k check; only overflow pulses.
- ENC_STACK_KCHECK_EN undefined:
  - All words are stored regardless of k.
  - k_err is tied to 0.

## Test plan
- Reset, then push (data,k) = (0x1,1),(0x2,2),(0x3,3), last on the third -> out replays (3,3),(2,2),(1,1); out_last only on (1,1); frame_len=3; in_ready=1 after the final handshake.
- Push 17 words 1..17 with last on 17 -> overflow pulses once; replay order 16..1; frame_len=16; out_last on word 1.
- Drain frame 10,20,30 with out_ready toggling 1,0,0,1,0,1 -> outputs stable while stalled; exactly 3 handshakes; no words lost or repeated.
- Assert rst after 2 of 4 replay handshakes -> all outputs 0, ptr=0; a new single-word frame (0xAB,8,last) replays as (0xAB,8,out_last=1).
- ENC_STACK_KCHECK_EN defined: push (5,0),(6,33),(7,4,last) -> k_err pulses twice; only (7,4) is replayed, with out_last=1.
- ENC_STACK_KCHECK_EN undefined: push (5,0,last) -> the word is stored; replay gives (5,0,out_last=1); k_err stays 0.
